// File: rtl/heading_if.sv
// Producer-to-transmitter link for one heading frame: P/Q request in, framed lanes out.
// Handshake: a frame is accepted on a rising edge where confirm=1 and ready=1; confirm at any other time is dropped.
interface heading_if;
  logic       confirm;
  logic [6:0] dataP;
  logic [6:0] dataQ;
  logic       ready;
  logic [2:0] dout;
  logic [7:0] outputData;
  logic       valid;
  logic       done;
  logic [2:0] state;

  modport master (
    output confirm, dataP, dataQ,
    input  ready, dout, outputData, valid, done, state
  );

  modport slave (
    input  confirm, dataP, dataQ,
    output ready, dout, outputData, valid, done, state
  );
endinterface

// File: rtl/heading_tx.sv
// Heading link transmitter: header code, parity-protected P and Q bytes, idle gap, done pulse.
// Every output is a flop loaded from the next-state decode, so lanes change with the state register.
module heading_tx #(
  parameter logic [2:0] HEAD_CODE   = 3'b111,
  parameter int         HEAD_CYCLES = 1,
  parameter int         GAP_CYCLES  = 2,
  parameter bit         PARITY_ODD  = 1'b0
) (
  input logic     clk,
  input logic     rst,
  heading_if.slave hif
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HEAD  = 3'd1,
    SENDP = 3'd2,
    SENDQ = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] HEAD_LAST = 8'(HEAD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

  state_t     st_q, st_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] p_q, p_d, q_q, q_d;
  logic       ready_q, ready_d;
  logic [2:0] dout_q, dout_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;

  function automatic logic par(input logic [6:0] v);
    return PARITY_ODD ? ~^v : ^v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      ready_q <= 1'b1;
      dout_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      ready_q <= ready_d;
      dout_q  <= dout_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    p_d     = p_q;
    q_d     = q_q;
    ready_d = 1'b0;
    dout_d  = '0;
    data_d  = '0;
    valid_d = 1'b0;
    done_d  = 1'b0;

    case (st_q)
      IDLE: begin
        if (hif.confirm) begin
          st_d = HEAD;
          p_d  = hif.dataP;
          q_d  = hif.dataQ;
        end
      end
      HEAD:    if (cnt_q == HEAD_LAST) st_d = SENDP;
      SENDP:   st_d = SENDQ;
      SENDQ:   st_d = GAP;
      GAP:     if (cnt_q == GAP_LAST) st_d = DONE;
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase

    // Counter restarts on every state entry so HEAD and GAP each count from zero.
    cnt_d = (st_d != st_q) ? 8'd0 : cnt_q + 8'd1;

    case (st_d)
      IDLE:  ready_d = 1'b1;
      HEAD:  dout_d  = HEAD_CODE;
      SENDP: begin
        data_d  = {par(p_d), p_d};
        valid_d = 1'b1;
      end
      SENDQ: begin
        data_d  = {par(q_d), q_d};
        valid_d = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  assign hif.ready      = ready_q;
  assign hif.dout       = dout_q;
  assign hif.outputData = data_q;
  assign hif.valid      = valid_q;
  assign hif.done       = done_q;
  assign hif.state      = st_q;
endmodule
